// File: rtl/dfm_pkg.sv
// Shared types and defaults for the frequency-meter measurement sequencer.
package dfm_pkg;

   localparam int unsigned GATE_W_DEFAULT     = 24;
   localparam int unsigned SETTLE_CYC_DEFAULT = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_GATE,
      ST_SETTLE,
      ST_LATCH_WAIT
   } dfm_state_t;

endpackage

// File: rtl/dfm_sequencer_gate_timer.sv
// Gate-length down-counter; a zero length is clamped to one cycle.
module gate_timer
   import dfm_pkg::*;
#(
   parameter int unsigned GATE_W = GATE_W_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load,
   input  logic              enable,
   input  logic [GATE_W-1:0] len,
   output logic              done
);

   localparam logic [GATE_W-1:0] ONE = GATE_W'(1);

   logic [GATE_W-1:0] count;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count <= '0;
      end else if (load) begin
         count <= (len == '0) ? ONE : len;
      end else if (enable && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign done = (count == ONE);

endmodule

// File: rtl/dfm_sequencer.sv
// Measurement sequencer: clear, gate, settle, then latch once the SPI read path is idle.
module dfm_sequencer
   import dfm_pkg::*;
#(
   parameter int unsigned GATE_W     = GATE_W_DEFAULT,
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEFAULT,
   parameter int unsigned SEQ_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              auto_i,
   input  logic [GATE_W-1:0] gate_len_i,
   input  logic              rd_busy_i,
   input  logic              rdy_clr_i,
   output logic              cnt_clr_o,
   output logic              gate_en_o,
   output logic              latch_o,
   output logic              busy_o,
   output logic              data_rdy_o,
   output logic [SEQ_W-1:0]  seq_cnt_o
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   dfm_state_t state, state_nx;
   logic [3:0] settle_cnt;
   logic       settle_done;
   logic       gate_done;
   logic       load_gate;
   logic       latch_evt;

   gate_timer #(.GATE_W(GATE_W)) u_gate_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load    (load_gate),
      .enable  (state == ST_GATE),
      .len     (gate_len_i),
      .done    (gate_done)
   );

   assign settle_done = (settle_cnt == SETTLE_LAST);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      load_gate = 1'b0;
      latch_evt = 1'b0;
      if (abort_i && (state != ST_IDLE)) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i && !abort_i) begin
                  state_nx  = ST_CLEAR;
                  load_gate = 1'b1;
               end
            end
            ST_CLEAR:      state_nx = ST_GATE;
            ST_GATE:       if (gate_done) state_nx = ST_SETTLE;
            ST_SETTLE: begin
               if (settle_done) begin
                  if (rd_busy_i) state_nx = ST_LATCH_WAIT;
                  else           latch_evt = 1'b1;
               end
            end
            ST_LATCH_WAIT: if (!rd_busy_i) latch_evt = 1'b1;
            default:       state_nx = ST_IDLE;
         endcase
         if (latch_evt) begin
            state_nx  = auto_i ? ST_CLEAR : ST_IDLE;
            load_gate = auto_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         settle_cnt <= '0;
      end else if (state != ST_SETTLE) begin
         settle_cnt <= '0;
      end else begin
         settle_cnt <= settle_cnt + 4'd1;
      end
   end

   // Outputs are registered from the next state, so they line up with the state they describe.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_clr_o  <= 1'b0;
         gate_en_o  <= 1'b0;
         latch_o    <= 1'b0;
         busy_o     <= 1'b0;
         data_rdy_o <= 1'b0;
         seq_cnt_o  <= '0;
      end else begin
         cnt_clr_o <= (state_nx == ST_CLEAR);
         gate_en_o <= (state_nx == ST_GATE);
         busy_o    <= (state_nx != ST_IDLE);
         latch_o   <= latch_evt;
         // An acknowledge landing on the latch edge or during the strobe cycle must not eat the new result.
         if (latch_evt) begin
            data_rdy_o <= 1'b1;
            seq_cnt_o  <= seq_cnt_o + SEQ_W'(1);
         end else if (rdy_clr_i && !latch_o) begin
            data_rdy_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dfm_sequencer.sv
// Self-checking bench for dfm_sequencer against a cycle-offset timing model.
module tb_dfm_sequencer;

   localparam int unsigned SETTLE = 4;
   localparam int unsigned GW     = 24;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, auto_m, rd_busy, rdy_clr;
   logic [GW-1:0] gate_len;
   logic          cnt_clr, gate_en, latch, busy, data_rdy;
   logic [7:0]    seq_cnt;

   int ntests = 0;
   int nfail  = 0;
   int exp_seq = 0;
   bit exp_rdy = 1'b0;
   bit prev_latch = 1'b0;
   int period, mlast, m, r, len_r;

   always #5 clk = ~clk;

   dfm_sequencer #(.GATE_W(GW), .SETTLE_CYC(SETTLE), .SEQ_W(8)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .start_i    (start),
      .abort_i    (abort),
      .auto_i     (auto_m),
      .gate_len_i (gate_len),
      .rd_busy_i  (rd_busy),
      .rdy_clr_i  (rdy_clr),
      .cnt_clr_o  (cnt_clr),
      .gate_en_o  (gate_en),
      .latch_o    (latch),
      .busy_o     (busy),
      .data_rdy_o (data_rdy),
      .seq_cnt_o  (seq_cnt)
   );

   task automatic check(input string tag, input int cyc, input logic [12:0] want);
      logic [12:0] got;
      got = {cnt_clr, gate_en, latch, busy, data_rdy, seq_cnt};
      ntests++;
      assert (got === want) else begin
         nfail++;
         $error("FAIL %s cycle %0d: got clr/gate/latch/busy/rdy/seq=%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%0d",
                tag, cyc, got[12], got[11], got[10], got[9], got[8], got[7:0],
                want[12], want[11], want[10], want[9], want[8], want[7:0]);
      end
   endtask

   // Advance one edge with the currently driven inputs, update the result model, compare.
   task automatic step(input string tag, input int cyc, input bit e_clr, input bit e_gate,
                       input bit e_lat, input bit e_busy);
      bit clr_s;
      clr_s = rdy_clr;
      @(posedge clk);
      #1;
      if (e_lat) begin
         exp_rdy = 1'b1;
         exp_seq = (exp_seq + 1) % 256;
      end else if (clr_s && !prev_latch) begin
         exp_rdy = 1'b0;
      end
      prev_latch = e_lat;
      check(tag, cyc, {e_clr, e_gate, e_lat, e_busy, exp_rdy, 8'(exp_seq)});
   endtask

   // One single-shot measurement; rd_busy high while driving cycles [bs, bs+bl).
   task automatic run_one(input string tag, input int len, input int bs, input int bl,
                          input int c1, input int c2, input int st_k);
      int n, lat;
      n   = (len == 0) ? 1 : len;
      lat = n + 2 + SETTLE;
      while ((lat - 1 >= bs) && (lat - 1 < bs + bl)) lat++;
      gate_len = GW'(len);
      for (int k = 0; k <= lat; k++) begin
         start   = (k == 0) || (k == st_k);
         rd_busy = (k >= bs) && (k < bs + bl);
         rdy_clr = (k == c1) || (k == c2);
         if (k > 0) gate_len = GW'($urandom);
         step(tag, k + 1, (k + 1) == 1, ((k + 1) >= 2) && ((k + 1) <= n + 1),
              (k + 1) == lat, (k + 1) < lat);
      end
      start = 1'b0; rd_busy = 1'b0; rdy_clr = 1'b0;
   endtask

   task automatic run_abort(input string tag, input int len, input int ab_k, input int tail);
      int n;
      n = (len == 0) ? 1 : len;
      gate_len = GW'(len);
      for (int k = 0; k <= ab_k + tail; k++) begin
         start = (k == 0);
         abort = (k == ab_k);
         if (k + 1 <= ab_k)
            step(tag, k + 1, (k + 1) == 1, ((k + 1) >= 2) && ((k + 1) <= n + 1), 1'b0, 1'b1);
         else
            step(tag, k + 1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      start = 1'b0; abort = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; auto_m = 1'b0;
      rd_busy = 1'b0; rdy_clr = 1'b0; gate_len = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset", 0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      step("idle", 1, 1'b0, 1'b0, 1'b0, 1'b0);

      run_one("basic", 10, 1000, 0, -1, -1, -1);
      run_one("zero_len", 0, 1000, 0, 2, -1, -1);
      run_one("deferred", 10, 13, 20, -1, -1, -1);
      run_one("ack_race", 5, 1000, 0, 10, 11, -1);
      rdy_clr = 1'b1;
      step("ack_alone", 1, 1'b0, 1'b0, 1'b0, 1'b0);
      rdy_clr = 1'b0;
      step("ack_alone", 2, 1'b0, 1'b0, 1'b0, 1'b0);

      run_abort("abort_gate", 100, 6, 20);
      run_abort("abort_at_latch", 2, 7, 5);

      start = 1'b1; abort = 1'b1;
      step("start_abort_idle", 1, 1'b0, 1'b0, 1'b0, 1'b0);
      start = 1'b0; abort = 1'b0;
      for (int i = 2; i <= 4; i++) step("start_abort_idle", i, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         len_r = $urandom_range(0, 20);
         run_one("random", len_r, $urandom_range(0, 35), $urandom_range(0, 15),
                 $urandom_range(0, 40), -1, $urandom_range(1, len_r + 1));
      end

      gate_len = GW'(50);
      start = 1'b1;
      step("rst_mid_gate", 1, 1'b1, 1'b0, 1'b0, 1'b1);
      start = 1'b0;
      for (int i = 2; i <= 10; i++) step("rst_mid_gate", i, 1'b0, 1'b1, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      exp_seq = 0; exp_rdy = 1'b0; prev_latch = 1'b0;
      check("rst_async", 0, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 3; i++) step("after_rst", i, 1'b0, 1'b0, 1'b0, 1'b0);

      auto_m = 1'b1;
      gate_len = GW'(3);
      period = 3 + 1 + SETTLE;
      mlast = 1 + 300 * period;
      for (int k = 0; k < mlast; k++) begin
         m = k + 1;
         r = (m - 1) % period;
         start   = (k == 0) || (k == 3);
         rdy_clr = ($urandom_range(0, 3) == 0);
         if (m == mlast) auto_m = 1'b0;
         step("auto", m, (r == 0) && (m != mlast), (r >= 1) && (r <= 3),
              (m > 1) && (r == 0), m != mlast);
      end
      start = 1'b0; rdy_clr = 1'b0;
      step("auto_end", 1, 1'b0, 1'b0, 1'b0, 1'b0);
      ntests++;
      assert (seq_cnt === 8'd44) else begin
         nfail++;
         $error("FAIL seq_wrap: got %0d want 44", seq_cnt);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
